// File: rtl/flit_mon_pkg.sv
// Shared types, sizing constants and the walking-ones reference pattern for the
// flit receive monitor.
package flit_mon_pkg;

  localparam int unsigned W          = 62;
  localparam int unsigned S          = 4;
  localparam int unsigned PAYLOAD    = 20;
  localparam int unsigned CNT_W      = 16;
  localparam int unsigned TOG_W      = 32;
  localparam int unsigned MIN_GAP    = 7;
  localparam int unsigned GAP_W      = 16;

  localparam int unsigned PAT_F      = W / S;
  localparam int unsigned PAT_PERIOD = 2 * PAT_F + 1;
  localparam int unsigned IDX_W      = $clog2(PAT_PERIOD);
  localparam int unsigned BEAT_W     = $clog2(PAYLOAD);
  localparam int unsigned POP_W      = $clog2(W + 1);
  localparam int unsigned TOG_SUM_W  = TOG_W + 1;

  typedef enum logic {
    RECV   = 1'b0,
    STATUS = 1'b1
  } state_t;

  // Wrapping successor of a pattern index (2F -> 0)
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] nxt;
    if (32'(idx) == PAT_PERIOD - 1) nxt = '0;
    else                            nxt = idx + IDX_W'(1);
    return nxt;
  endfunction

  // E(n): fill from the top in S-bit steps, then drain from the top
  function automatic logic [W-1:0] expected_flit(input logic [IDX_W-1:0] idx);
    logic [W-1:0] p;
    int unsigned  n;
    int unsigned  ones;
    p    = '0;
    n    = 32'(idx);
    ones = 0;
    if (n >= 1 && n <= PAT_F) begin
      ones = n * S;
      for (int unsigned b = 0; b < W; b++) p[b] = (b >= W - ones);
    end else if (n > PAT_F && n < PAT_PERIOD) begin
      ones = (2 * PAT_F - n + 1) * S;
      for (int unsigned b = 0; b < W; b++) p[b] = (b < ones);
    end
    return p;
  endfunction

endpackage

// File: rtl/flit_pattern_gen.sv
// Pattern index tracker. r_idx counts pattern steps taken in the current packet,
// so the flit expected next is E(r_idx + 1), i.e. E(1) for the first flit.
module flit_pattern_gen
  import flit_mon_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         i_advance,
  input  logic         i_restart,
  output logic [W-1:0] o_expected_c
);

  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_next;

  assign w_idx_next = next_idx(r_idx);

  always_ff @(posedge clk) begin
    if (rst || i_restart) r_idx <= '0;
    else if (i_advance)   r_idx <= w_idx_next;
  end

  assign o_expected_c = expected_flit(w_idx_next);

endmodule

// File: rtl/flit_rx_monitor.sv
// Receive-side flit characterisation monitor: pattern check, packet/flit/error
// counters and toggle accumulator. Define GAP_MON_EN for inter-packet gap monitoring.
module flit_rx_monitor
  import flit_mon_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             in_ready,
  input  logic             clear,
  output logic             pkt_done,
  output logic             pkt_err,
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] err_count,
  output logic [TOG_W-1:0] flit_count,
  output logic [TOG_W-1:0] toggle_acc
`ifdef GAP_MON_EN
  ,
  output logic [GAP_W-1:0] last_gap,
  output logic             gap_err
`endif
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_in_ready;
  logic               w_in_ready_nxt;
  logic               r_pkt_done;
  logic               w_pkt_done_nxt;
  logic               r_pkt_err;
  logic               w_pkt_err_nxt;

  logic               r_err_flag;
  logic [BEAT_W-1:0]  r_beat;
  logic [W-1:0]       r_prev_data;
  logic [W-1:0]       w_expected;
  logic [W-1:0]       w_diff;
  logic [POP_W-1:0]   w_pop;
  logic [TOG_SUM_W-1:0] w_tog_sum;

  logic [CNT_W-1:0]   r_pkt_count;
  logic [CNT_W-1:0]   r_err_count;
  logic [TOG_W-1:0]   r_flit_count;
  logic [TOG_W-1:0]   r_toggle_acc;

  logic               w_accept;
  logic               w_last;
  logic               w_mismatch;
  logic               w_in_status;

  assign w_accept    = in_valid && r_in_ready;
  assign w_last      = w_accept && (r_beat == BEAT_W'(PAYLOAD - 1));
  assign w_mismatch  = (in_data != w_expected);
  assign w_in_status = (r_state == STATUS);

  flit_pattern_gen u_pattern_gen (
    .clk          (clk),
    .rst          (rst),
    .i_advance    (w_accept),
    .i_restart    (w_in_status),
    .o_expected_c (w_expected)
  );

  // State register plus registered handshake/status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RECV;
      r_in_ready <= 1'b1;
      r_pkt_done <= 1'b0;
      r_pkt_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= w_in_ready_nxt;
      r_pkt_done <= w_pkt_done_nxt;
      r_pkt_err  <= w_pkt_err_nxt;
    end
  end

  // Next state; output values are those to be shown in the next state
  always_comb begin
    w_state_nxt    = r_state;
    w_in_ready_nxt = 1'b1;
    w_pkt_done_nxt = 1'b0;
    w_pkt_err_nxt  = 1'b0;
    case (r_state)
      RECV: begin
        if (w_last) begin
          w_state_nxt    = STATUS;
          w_in_ready_nxt = 1'b0;
          w_pkt_done_nxt = 1'b1;
          w_pkt_err_nxt  = r_err_flag || w_mismatch;
        end
      end
      STATUS: begin
        w_state_nxt = RECV;
      end
      default: begin
        w_state_nxt = RECV;
      end
    endcase
  end

  // Per-packet beat count, sticky error and last-flit history
  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat      <= '0;
      r_err_flag  <= 1'b0;
      r_prev_data <= '0;
    end else if (w_in_status) begin
      r_beat      <= '0;
      r_err_flag  <= 1'b0;
    end else if (w_accept) begin
      r_beat      <= w_last ? '0 : r_beat + BEAT_W'(1);
      r_prev_data <= in_data;
      if (w_mismatch) r_err_flag <= 1'b1;
    end
  end

  // Hamming distance to the previous accepted flit
  assign w_diff = in_data ^ r_prev_data;

  always_comb begin
    w_pop = '0;
    for (int unsigned i = 0; i < W; i++) w_pop = w_pop + POP_W'(w_diff[i]);
  end

  assign w_tog_sum = {1'b0, r_toggle_acc} + TOG_SUM_W'(w_pop);

  // Saturating statistics; clear touches only these
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_pkt_count  <= '0;
      r_err_count  <= '0;
      r_flit_count <= '0;
      r_toggle_acc <= '0;
    end else begin
      if (w_in_status) begin
        if (r_pkt_count != '1) r_pkt_count <= r_pkt_count + CNT_W'(1);
        if (r_pkt_err && (r_err_count != '1)) r_err_count <= r_err_count + CNT_W'(1);
      end
      if (w_accept) begin
        if (r_flit_count != '1) r_flit_count <= r_flit_count + TOG_W'(1);
        r_toggle_acc <= w_tog_sum[TOG_W] ? '1 : w_tog_sum[TOG_W-1:0];
      end
    end
  end

`ifdef GAP_MON_EN
  logic [GAP_W-1:0] r_gap_cnt;
  logic [GAP_W-1:0] r_last_gap;
  logic             r_gap_err;
  logic             r_gap_armed;
  logic             w_first_flit;

  assign w_first_flit = w_accept && (r_beat == '0);

  // Idle cycles after STATUS up to the next packet's first flit
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_gap_cnt   <= '0;
      r_last_gap  <= '0;
      r_gap_err   <= 1'b0;
      r_gap_armed <= 1'b0;
    end else begin
      if (w_in_status) begin
        r_gap_cnt   <= '0;
        r_gap_armed <= 1'b1;
      end else if (r_gap_cnt != '1) begin
        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
      end
      if (w_first_flit && r_gap_armed) begin
        r_last_gap  <= r_gap_cnt;
        r_gap_armed <= 1'b0;
        if (r_gap_cnt < GAP_W'(MIN_GAP)) r_gap_err <= 1'b1;
      end
    end
  end

  assign last_gap = r_last_gap;
  assign gap_err  = r_gap_err;
`endif

  assign in_ready   = r_in_ready;
  assign pkt_done   = r_pkt_done;
  assign pkt_err    = r_pkt_err;
  assign pkt_count  = r_pkt_count;
  assign err_count  = r_err_count;
  assign flit_count = r_flit_count;
  assign toggle_acc = r_toggle_acc;

endmodule

// File: tb/tb_flit_rx_monitor.sv
// Directed bench for flit_rx_monitor: packet-level vector table plus hand-written
// reset, mid-packet reset and (with GAP_MON_EN) gap-monitor sequences.
module tb_flit_rx_monitor;
  import flit_mon_pkg::*;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [W-1:0]     in_data;
  logic             in_ready;
  logic             clear;
  logic             pkt_done;
  logic             pkt_err;
  logic [CNT_W-1:0] pkt_count;
  logic [CNT_W-1:0] err_count;
  logic [TOG_W-1:0] flit_count;
  logic [TOG_W-1:0] toggle_acc;
`ifdef GAP_MON_EN
  logic [GAP_W-1:0] last_gap;
  logic             gap_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int done_pulses = 0;

  flit_rx_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .clear      (clear),
    .pkt_done   (pkt_done),
    .pkt_err    (pkt_err),
    .pkt_count  (pkt_count),
    .err_count  (err_count),
    .flit_count (flit_count),
    .toggle_acc (toggle_acc)
`ifdef GAP_MON_EN
    ,
    .last_gap   (last_gap),
    .gap_err    (gap_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (pkt_done) done_pulses++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit rst_first;
    int gap;
    int flip_flit;
    int flip_bit;
    int stall_after;
    int stall_len;
    bit clr;
    bit e_err;
    int e_pkts;
    int e_errs;
    int e_flits;
    int e_tog;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  // Reference walking-ones pattern built from shifted all-ones masks
  function automatic logic [61:0] tb_pat(input int n);
    logic [61:0] all1;
    logic [61:0] p;
    all1 = '1;
    if (n == 0)       p = '0;
    else if (n <= 15) p = all1 << (62 - n * 4);
    else              p = all1 >> (62 - (31 - n) * 4);
    return p;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_data  = '0;
    clear    = 1'b0;
    rst      = 1'b1;
    repeat (2) @(negedge clk);
    rst      = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_in_ready"},   64'(in_ready),   1);
    chk({tag, "_pkt_done"},   64'(pkt_done),   0);
    chk({tag, "_pkt_err"},    64'(pkt_err),    0);
    chk({tag, "_pkt_count"},  64'(pkt_count),  0);
    chk({tag, "_err_count"},  64'(err_count),  0);
    chk({tag, "_flit_count"}, 64'(flit_count), 0);
    chk({tag, "_toggle_acc"}, 64'(toggle_acc), 0);
  endtask

  // Sends flits 1..n; for a full packet checks the STATUS cycle and returns pkt_err
  task automatic send_pkt(input int n, input int ff, input int fb, input int sa,
                          input int sl, input bit clr, output bit perr);
    logic [61:0] d;
    int guard;
    perr = 1'b0;
    for (int i = 1; i <= n; i++) begin
      d = tb_pat(i);
      if (i == ff) d[fb] = ~d[fb];
      in_valid = 1'b1;
      in_data  = d;
      guard = 0;
      while (!in_ready && guard < 40) begin
        @(negedge clk);
        guard++;
      end
      if (!in_ready) begin
        n_tests++;
        n_fail++;
        $display("FAIL ready_timeout: in_ready stayed 0 at flit %0d", i);
      end
      @(negedge clk);
      if (i == sa) begin
        in_valid = 1'b0;
        repeat (sl) @(negedge clk);
      end
    end
    in_valid = 1'b0;
    in_data  = '0;
    if (n == int'(PAYLOAD)) begin
      chk("done_latency", 64'(pkt_done), 1);
      chk("ready_low_in_status", 64'(in_ready), 0);
      perr  = pkt_err;
      clear = clr;
      @(negedge clk);
      clear = 1'b0;
      chk("done_one_cycle", 64'(pkt_done), 0);
    end
  endtask

  initial begin
    vec_t v;
    bit   got_err;

    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    clear    = 1'b0;

    //        rst gap ff fb  sa sl clr  err pk er fl  tog
    vecs[0] = '{1, 0,  0,  0,  0, 0, 0,  0, 1, 0, 20,  80};
    vecs[1] = '{0, 7,  0,  0,  0, 0, 0,  0, 2, 0, 40, 204};
    vecs[2] = '{1, 0,  5,  0,  0, 0, 0,  1, 1, 1, 20,  82};
    vecs[3] = '{0, 7,  0,  0,  0, 0, 0,  0, 2, 1, 40, 206};
    vecs[4] = '{1, 0,  0,  0, 10, 3, 0,  0, 1, 0, 20,  80};
    vecs[5] = '{1, 0, 16, 61,  0, 0, 0,  1, 1, 1, 20,  80};
    vecs[6] = '{1, 0, 20, 43,  0, 0, 0,  1, 1, 1, 20,  81};
    vecs[7] = '{0, 2,  1, 61,  0, 0, 0,  1, 2, 2, 40, 204};
    vecs[8] = '{1, 0,  3, 10,  0, 0, 1,  1, 0, 0,  0,   0};
    vecs[9] = '{0, 0,  0,  0,  0, 0, 0,  0, 1, 0, 20, 124};

    do_reset();
    check_reset_state("reset");

    for (int k = 0; k < NV; k++) begin
      v = vecs[k];
      if (v.rst_first) do_reset();
      repeat (v.gap) @(negedge clk);
      send_pkt(int'(PAYLOAD), v.flip_flit, v.flip_bit, v.stall_after, v.stall_len, v.clr, got_err);
      chk($sformatf("v%0d_pkt_err", k),    64'(got_err),    64'(v.e_err));
      chk($sformatf("v%0d_pkt_count", k),  64'(pkt_count),  64'(v.e_pkts));
      chk($sformatf("v%0d_err_count", k),  64'(err_count),  64'(v.e_errs));
      chk($sformatf("v%0d_flit_count", k), 64'(flit_count), 64'(v.e_flits));
      chk($sformatf("v%0d_toggle_acc", k), 64'(toggle_acc), 64'(v.e_tog));
    end

    // Reset after flit 12 discards the partial packet
    do_reset();
    done_pulses = 0;
    send_pkt(12, 0, 0, 0, 0, 1'b0, got_err);
    do_reset();
    check_reset_state("midrst");
    send_pkt(int'(PAYLOAD), 0, 0, 0, 0, 1'b0, got_err);
    chk("midrst_done_pulses", 64'(done_pulses), 1);
    chk("midrst_pkt_err",     64'(got_err),     0);
    chk("midrst_pkt_count",   64'(pkt_count),   1);
    chk("midrst_flit_count",  64'(flit_count),  20);
    chk("midrst_toggle_acc",  64'(toggle_acc),  80);

`ifdef GAP_MON_EN
    do_reset();
    send_pkt(int'(PAYLOAD), 0, 0, 0, 0, 1'b0, got_err);
    repeat (7) @(negedge clk);
    send_pkt(int'(PAYLOAD), 0, 0, 0, 0, 1'b0, got_err);
    chk("gap7_last_gap", 64'(last_gap), 7);
    chk("gap7_gap_err",  64'(gap_err),  0);
    repeat (3) @(negedge clk);
    send_pkt(int'(PAYLOAD), 0, 0, 0, 0, 1'b0, got_err);
    chk("gap3_last_gap", 64'(last_gap), 3);
    chk("gap3_gap_err",  64'(gap_err),  1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("gapclr_last_gap", 64'(last_gap), 0);
    chk("gapclr_gap_err",  64'(gap_err),  0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
